ghost_motion: RTL
=================

GHOST_MOTION -- requirements
Module: ghost_motion

Interface
REQ-001 Parameter HOME_X, default 11'd304, ghost home/respawn x pixel (multiple of 16).
REQ-002 Parameter HOME_Y, default 10'd224, ghost home/respawn y pixel (multiple of 16).
REQ-003 Parameter X_MIN, default 11'd0, leftmost tunnel x (multiple of 16).
REQ-004 Parameter X_MAX, default 11'd624, rightmost tunnel x (multiple of 16).
REQ-005 Parameter RESPAWN_TICKS, default 8'd120, move_tick count spent in DEAD before returning to MOVE.
REQ-006 clk  input  1  single system clock; all logic rising-edge.
REQ-007 rst  input  1  synchronous, active-low reset.
REQ-008 move_tick  input  1  one-cycle step enable (slow movement rate), qualifies all motion.
REQ-009 enable  input  1  game running; low freezes motion.
REQ-010 caught  input  1  one-cycle pulse, ghost eaten/collided.
REQ-011 move_direction  input  4  requested one-hot direction from the ghost controller: RIGHT 0001, UP 0010, DOWN 0100, LEFT 1000.
REQ-012 valid_moves  input  4  one-hot-mask of open directions at current position, same encoding.
REQ-013 ghost_pos_x  output  11  current ghost x pixel.
REQ-014 ghost_pos_y  output  10  current ghost y pixel.
REQ-015 prev_direction  output  4  currently latched direction, fed back to the controller; 0000 = stopped.
REQ-016 aligned  output  1  high when ghost_pos_x[3:0]==0 and ghost_pos_y[3:0]==0 (combinational from registers).
REQ-017 step_done  output  1  one-cycle pulse the cycle after any position change.
REQ-018 dead  output  1  high while in DEAD state.

Function
REQ-019 FSM states IDLE, MOVE, DEAD; encoding free.
REQ-020 IDLE: position held at home, prev_direction 0000; enable high -> MOVE next cycle.
REQ-021 MOVE, move_tick high, enable high, aligned high: request accepted iff move_direction is exactly one-hot and (move_direction & valid_moves)!=0; then prev_direction <= move_direction and one-pixel step taken in that direction, same edge.
REQ-022 MOVE, aligned, request not accepted: if (prev_direction & valid_moves)!=0 continue one step in prev_direction; else prev_direction <= 0000, no step.
REQ-023 MOVE, move_tick high, not aligned: step one pixel in prev_direction; move_direction and valid_moves ignored.
REQ-024 Reversal permitted only at alignment (policy belongs to the controller).
REQ-025 Step arithmetic: RIGHT x+1, LEFT x-1, DOWN y+1, UP y-1; exactly one pixel per accepted move_tick.
REQ-026 Wrap: LEFT step at x==X_MIN sets x=X_MAX; RIGHT step at x==X_MAX sets x=X_MIN; counts as a step (step_done pulses).
REQ-027 Y never wraps: UP at y==0 or DOWN at y==10'd1023 -> no step, prev_direction <= 0000.
REQ-028 move_tick low or enable low: position, direction, FSM held; no step_done.
REQ-029 caught high in MOVE (any cycle, regardless of move_tick): -> DEAD, position <= HOME, prev_direction <= 0000, respawn counter <= 0; caught beats a simultaneous move_tick.
REQ-030 DEAD: counter increments on each move_tick; at counter==RESPAWN_TICKS-1 with move_tick -> MOVE next cycle; caught in DEAD ignored; enable low freezes the counter.
REQ-031 caught in IDLE ignored.
REQ-032 step_done is registered: asserted exactly one cycle after the edge that changed position; never asserted for the HOME jump.

Reset
REQ-033 rst low at a clock edge: state IDLE, ghost_pos_x=HOME_X, ghost_pos_y=HOME_Y, prev_direction=0000, step_done=0, dead=0, counter=0; overrides all inputs, including mid-step and mid-DEAD.
REQ-034 Outputs valid from the first edge after rst deasserts; no other reset source.

Verification
REQ-035 Reset, enable=1, move_direction=RIGHT, valid_moves=1001, 16 ticks -> x 304->320, aligned low for ticks 1-15, high after 16th, prev_direction=0001, 16 step_done pulses.
REQ-036 At x=320 mid-way (x=312) request UP -> ignored, continues RIGHT to 320; at 320 with valid_moves=0010 and UP -> y decrements 224->223, prev_direction=0010.
REQ-037 Aligned, valid_moves=0100, move_direction=RIGHT, prev_direction=RIGHT -> prev_direction=0000, no step, no step_done.
REQ-038 x=0 moving LEFT, one tick -> x=624, step_done pulses; x=624 RIGHT -> x=0.
REQ-039 caught with move_tick same cycle at x=317 -> next cycle position (304,224), dead=1, no step_done; after 120 ticks dead=0, state MOVE.
REQ-040 rst low during DEAD at tick 50 -> IDLE, home, counter 0; rst low with move_tick high -> no step.

Source files
------------

// File: rtl/ghost_motion.sv
// ghost_motion: pixel-stepped ghost movement with tunnel wrap and a death/respawn timer.
//
// Ports:
//   i_clk              system clock, rising edge
//   i_rst              synchronous active-low reset
//   i_move_tick        one-cycle step enable; qualifies all motion and the respawn timer
//   i_enable           game running; low freezes motion and the respawn timer
//   i_caught           one-cycle pulse, ghost eaten; only acted on while moving
//   i_move_direction   requested one-hot direction (RIGHT 0001, UP 0010, DOWN 0100, LEFT 1000)
//   i_valid_moves      mask of open directions at the current position, same encoding
//   o_ghost_pos_x      ghost x pixel
//   o_ghost_pos_y      ghost y pixel
//   o_prev_direction   latched direction, 0000 = stopped
//   o_aligned          both coordinates sit on the 16-pixel tile grid
//   o_step_done        high for the cycle following any step
//   o_dead             high while waiting to respawn
module ghost_motion #(
    parameter logic [10:0] HOME_X        = 11'd304,
    parameter logic [9:0]  HOME_Y        = 10'd224,
    parameter logic [10:0] X_MIN         = 11'd0,
    parameter logic [10:0] X_MAX         = 11'd624,
    parameter logic [7:0]  RESPAWN_TICKS = 8'd120
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_move_tick,
    input  logic        i_enable,
    input  logic        i_caught,
    input  logic [3:0]  i_move_direction,
    input  logic [3:0]  i_valid_moves,
    output logic [10:0] o_ghost_pos_x,
    output logic [9:0]  o_ghost_pos_y,
    output logic [3:0]  o_prev_direction,
    output logic        o_aligned,
    output logic        o_step_done,
    output logic        o_dead
);

    localparam logic [3:0] DIR_RIGHT = 4'b0001;
    localparam logic [3:0] DIR_UP    = 4'b0010;
    localparam logic [3:0] DIR_DOWN  = 4'b0100;
    localparam logic [3:0] DIR_LEFT  = 4'b1000;

    typedef enum logic [1:0] {StIdle, StMove, StDead} state_e;

    state_e      r_state, w_state_d;
    logic [10:0] r_x, w_x_d;
    logic [9:0]  r_y, w_y_d;
    logic [3:0]  r_dir, w_dir_d;
    logic [7:0]  r_cnt, w_cnt_d;
    logic        r_step_done, w_step;

    logic        w_aligned;
    logic        w_req_onehot;
    logic        w_req_accept;
    logic [3:0]  w_dir_sel;

    assign w_aligned    = (r_x[3:0] == 4'd0) && (r_y[3:0] == 4'd0);
    assign w_req_onehot = (i_move_direction != 4'd0)
                        && ((i_move_direction & (i_move_direction - 4'd1)) == 4'd0);
    assign w_req_accept = w_req_onehot && ((i_move_direction & i_valid_moves) != 4'd0);

    // Direction to travel this tick: new requests and wall checks only count on the grid;
    // between tiles the ghost keeps going the way it was already heading.
    always_comb begin
        w_dir_sel = r_dir;
        if (w_aligned) begin
            if (w_req_accept) begin
                w_dir_sel = i_move_direction;
            end else if ((r_dir & i_valid_moves) == 4'd0) begin
                w_dir_sel = 4'd0;
            end
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_x_d     = r_x;
        w_y_d     = r_y;
        w_dir_d   = r_dir;
        w_cnt_d   = r_cnt;
        w_step    = 1'b0;
        case (r_state)
            StIdle: begin
                w_x_d   = HOME_X;
                w_y_d   = HOME_Y;
                w_dir_d = 4'd0;
                if (i_enable) w_state_d = StMove;
            end
            StMove: begin
                if (i_caught) begin
                    // Caught wins over a coincident step; the home jump is not a step.
                    w_state_d = StDead;
                    w_x_d     = HOME_X;
                    w_y_d     = HOME_Y;
                    w_dir_d   = 4'd0;
                    w_cnt_d   = 8'd0;
                end else if (i_move_tick && i_enable) begin
                    w_dir_d = w_dir_sel;
                    case (w_dir_sel)
                        DIR_RIGHT: begin
                            w_x_d  = (r_x == X_MAX) ? X_MIN : r_x + 11'd1;
                            w_step = 1'b1;
                        end
                        DIR_LEFT: begin
                            w_x_d  = (r_x == X_MIN) ? X_MAX : r_x - 11'd1;
                            w_step = 1'b1;
                        end
                        DIR_UP: begin
                            // Screen edges in y are hard stops, not tunnels.
                            if (r_y == 10'd0) begin
                                w_dir_d = 4'd0;
                            end else begin
                                w_y_d  = r_y - 10'd1;
                                w_step = 1'b1;
                            end
                        end
                        DIR_DOWN: begin
                            if (r_y == 10'd1023) begin
                                w_dir_d = 4'd0;
                            end else begin
                                w_y_d  = r_y + 10'd1;
                                w_step = 1'b1;
                            end
                        end
                        default: w_dir_d = 4'd0;
                    endcase
                end
            end
            StDead: begin
                if (i_move_tick && i_enable) begin
                    if (r_cnt == RESPAWN_TICKS - 8'd1) begin
                        w_state_d = StMove;
                    end else begin
                        w_cnt_d = r_cnt + 8'd1;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state     <= StIdle;
            r_x         <= HOME_X;
            r_y         <= HOME_Y;
            r_dir       <= 4'd0;
            r_cnt       <= 8'd0;
            r_step_done <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_x         <= w_x_d;
            r_y         <= w_y_d;
            r_dir       <= w_dir_d;
            r_cnt       <= w_cnt_d;
            r_step_done <= w_step;
        end
    end

    assign o_ghost_pos_x    = r_x;
    assign o_ghost_pos_y    = r_y;
    assign o_prev_direction = r_dir;
    assign o_aligned        = w_aligned;
    assign o_step_done      = r_step_done;
    assign o_dead           = (r_state == StDead);

endmodule
